counter: RTL and testbench
==========================

Name: counter

Overview:
- Synchronous loadable up-counter with parameterised width; serves as the program counter in the RISC CPU datapath.
- Each clock edge it does one of three things: parallel-load a new value, increment by one (wrapping), or hold.
- Asynchronous active-low reset clears the count.

Parameters:
- COUNTER_WIDTH, 5, bit width of cnt_in and cnt_out; legal range 1 or more.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset; asynchronous, active-low (rst=0 clears the counter).
- load  input  1  synchronous parallel-load request, active-high.
- enable  input  1  synchronous count enable, active-high.
- cnt_in  input  COUNTER_WIDTH  value to load when load=1.
- cnt_out  output  COUNTER_WIDTH  current count, driven directly from the register.

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-low.
- Reset:
  - rst=0 forces cnt_out to 0 immediately, without waiting for a clock edge.
  - cnt_out holds 0 for as long as rst=0, regardless of load, enable or cnt_in.
- Release from reset: the first rising clk edge with rst=1 applies the normal update rules.
- Priority at each rising clk edge while rst=1:
  1. load=1: cnt_out <= cnt_in. This happens whatever enable is.
  2. load=0 and enable=1: cnt_out <= cnt_out + 1, modulo 2^COUNTER_WIDTH.
  3. load=0 and enable=0: cnt_out holds its value.
- Latency: a loaded or incremented value appears on cnt_out one clock after the controlling inputs are sampled. There is no combinational path from any input to cnt_out except through the asynchronous reset.
- Wrap-around: all-ones plus one gives all-zeros. No carry or overflow output.
- Simultaneous events:
  - rst=0 together with load=1: reset wins and cnt_out = 0.
  - load=1 together with enable=1: the load wins and no increment happens in that cycle.
- Reset mid-operation: asserting rst at any time clears cnt_out asynchronously. Any pending load or increment is discarded.
- Output is a pure register, so it is glitch-free between clock edges.
- No X-propagation masking: unknown inputs may propagate to cnt_out.

Test Plan (COUNTER_WIDTH=5; inputs driven on the falling edge, checked at the next falling edge):
- Load sequence, rst=1, load=1, enable=1: cnt_in=5'h15 -> 5'h15; then 5'h0A -> 5'h0A; then 5'h1F -> 5'h1F.
- Reset priority: from cnt_out=5'h1F, drive rst=0, load=1, cnt_in=5'h1F -> cnt_out=5'h00 immediately, before any clock edge, and remains 5'h00.
- Reload after reset: rst=1, load=1, cnt_in=5'h1F -> 5'h1F after one edge.
- Wrap-around: from 5'h1F, load=0, enable=1 -> 5'h00; a further edge -> 5'h01.
- Hold: load=0, enable=0 for 3 edges starting at 5'h07 -> stays 5'h07 throughout. Then enable=1 for 2 edges -> 5'h09.
- Asynchronous reset mid-count: while incrementing from 5'h0C, pulse rst low between clock edges -> cnt_out=5'h00 without a clock edge. After release with enable=1, one edge -> 5'h01.

Source files
------------

// File: rtl/counter.sv
// Loadable up-counter with parameterised width, used as the program counter.
// At each rising clock edge it parallel-loads, increments (wrapping) or holds,
// in that priority order. An active-low asynchronous reset clears the count.
module counter #(
    parameter int unsigned COUNTER_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     enable,
    input  logic [COUNTER_WIDTH-1:0] cnt_in,
    output logic [COUNTER_WIDTH-1:0] cnt_out
);

    logic [COUNTER_WIDTH-1:0] count;
    logic [COUNTER_WIDTH-1:0] count_next;

    // Next-state selection: load beats increment, increment beats hold.
    always_comb begin
        count_next = count;
        if (load) begin
            count_next = cnt_in;
        end else if (enable) begin
            count_next = count + COUNTER_WIDTH'(1);
        end
    end

    // Count register, cleared asynchronously while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    assign cnt_out = count;

endmodule

// File: tb/tb_counter.sv
module tb_counter;

  localparam int unsigned W = 5;

  logic         clk;
  logic         rst;
  logic         load;
  logic         enable;
  logic [W-1:0] cnt_in;
  logic [W-1:0] cnt_out;

  int total;
  int bad;

  counter #(.COUNTER_WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .enable (enable),
    .cnt_in (cnt_in),
    .cnt_out(cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic fail(input string name, input logic [W-1:0] val);
    bad++;
    $display("FAIL %s: cnt_out=%h expected=%h at %0t", name, cnt_out, val, $time);
  endtask

  task automatic drive(input logic l, input logic en, input logic [W-1:0] d);
    load   = l;
    enable = en;
    cnt_in = d;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b0;
    drive(1'b0, 1'b0, '0);
    @(negedge clk);
    total++; if (cnt_out !== 5'h00) fail("reset_state", 5'h00);

    rst = 1'b1;
    drive(1'b1, 1'b1, 5'h15);
    @(negedge clk);
    total++; if (cnt_out !== 5'h15) fail("load_15", 5'h15);
    drive(1'b1, 1'b1, 5'h0A);
    @(negedge clk);
    total++; if (cnt_out !== 5'h0A) fail("load_0A", 5'h0A);
    drive(1'b1, 1'b1, 5'h1F);
    @(negedge clk);
    total++; if (cnt_out !== 5'h1F) fail("load_1F", 5'h1F);

    rst = 1'b0;
    drive(1'b1, 1'b0, 5'h1F);
    #1;
    total++; if (cnt_out !== 5'h00) fail("rst_async", 5'h00);
    @(negedge clk);
    total++; if (cnt_out !== 5'h00) fail("rst_hold", 5'h00);

    rst = 1'b1;
    @(negedge clk);
    total++; if (cnt_out !== 5'h1F) fail("reload_1F", 5'h1F);

    drive(1'b0, 1'b1, 5'h00);
    @(negedge clk);
    total++; if (cnt_out !== 5'h00) fail("wrap_00", 5'h00);
    @(negedge clk);
    total++; if (cnt_out !== 5'h01) fail("wrap_01", 5'h01);

    drive(1'b1, 1'b0, 5'h07);
    @(negedge clk);
    total++; if (cnt_out !== 5'h07) fail("load_07", 5'h07);
    drive(1'b0, 1'b0, 5'h00);
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (cnt_out !== 5'h07) fail("hold_07", 5'h07);
    end
    drive(1'b0, 1'b1, 5'h00);
    @(negedge clk);
    total++; if (cnt_out !== 5'h08) fail("inc_08", 5'h08);
    @(negedge clk);
    total++; if (cnt_out !== 5'h09) fail("inc_09", 5'h09);

    drive(1'b1, 1'b0, 5'h0C);
    @(negedge clk);
    total++; if (cnt_out !== 5'h0C) fail("load_0C", 5'h0C);
    drive(1'b0, 1'b1, 5'h00);
    @(negedge clk);
    total++; if (cnt_out !== 5'h0D) fail("inc_0D", 5'h0D);
    #2;
    rst = 1'b0;
    #1;
    total++; if (cnt_out !== 5'h00) fail("rst_mid", 5'h00);
    #1;
    rst = 1'b1;
    @(negedge clk);
    total++; if (cnt_out !== 5'h01) fail("post_rst_01", 5'h01);

    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    if (bad != 0) $display("FAIL: %0d mismatches", bad);
    else $display("PASS");
    $finish;
  end

endmodule
